// File: rtl/dmem_wait_responder.sv
// Multi-cycle data-memory responder for the EX/MEM port.
// Serves one access at a time; stalls the pipeline for a fixed latency.
module dmem_wait_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic                  mem_stall,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  mem_err
);

    localparam int DEPTH = 2 ** (DM_ADDRESS - 2);
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DM_ADDRESS-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [2:0]              f3_q;
    logic                    load_q, store_q, err_q;

    logic [DATA_W-1:0]       mem [DEPTH];

    logic                    req, accept, err_in;
    logic                    misal, bad_ld, bad_st;
    logic [DATA_W-1:0]       word;
    logic [7:0]              sel_b;
    logic [15:0]             sel_h;
    logic [DATA_W-1:0]       ld_fmt;
    logic [DATA_W-1:0]       st_data;
    logic [3:0]              st_be;
    logic                    commit;

    assign req    = MemRead | MemWrite;
    assign accept = (state_q == IDLE) & req;

    // Classify the incoming access so the captured copy carries its verdict.
    always_comb begin
        misal  = ((func3[1:0] == 2'b01) & addr[0]) |
                 ((func3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        bad_ld = (func3 == 3'b011) | (func3 == 3'b110) |
                 (func3 == 3'b111);
        bad_st = (func3 != 3'b000) & (func3 != 3'b001) &
                 (func3 != 3'b010);
        err_in = (MemRead & MemWrite) | misal |
                 (MemRead & bad_ld) | (MemWrite & bad_st);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            load_q  <= 1'b0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wr_data;
                f3_q    <= func3;
                load_q  <= MemRead;
                store_q <= MemWrite;
                err_q   <= err_in;
            end
        end
    end

    assign word  = mem[addr_q[DM_ADDRESS-1:2]];
    assign sel_b = word[{addr_q[1:0], 3'b000} +: 8];
    assign sel_h = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  ld_fmt = {{(DATA_W-8){sel_b[7]}}, sel_b};
            3'b001:  ld_fmt = {{(DATA_W-16){sel_h[15]}}, sel_h};
            3'b010:  ld_fmt = word;
            3'b100:  ld_fmt = {{(DATA_W-8){1'b0}}, sel_b};
            3'b101:  ld_fmt = {{(DATA_W-16){1'b0}}, sel_h};
            default: ld_fmt = '0;
        endcase
    end

    // Replicate store data across lanes; the byte enables pick the lanes.
    always_comb begin
        st_data = wdata_q;
        st_be   = 4'b0000;
        case (f3_q)
            3'b000: begin
                st_data = {4{wdata_q[7:0]}};
                st_be   = 4'b0001 << addr_q[1:0];
            end
            3'b001: begin
                st_data = {2{wdata_q[15:0]}};
                st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            3'b010:  st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    assign commit = (state_q == DONE) & store_q & ~err_q & ~reset;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem[addr_q[DM_ADDRESS-1:2]][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    // Reset silences every output at once, even mid-access.
    assign mem_stall = ~reset & (accept | (state_q == WAIT));
    assign rd_valid  = ~reset & (state_q == DONE);
    assign mem_err   = rd_valid & err_q;
    assign rd_data   = (rd_valid & load_q & ~err_q) ? ld_fmt : '0;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Directed bench for dmem_wait_responder.
// Instance 0 uses two wait states, instance 1 uses none.
module tb_dmem_wait_responder;

    logic        clk;
    logic        reset;
    logic        mr   [2];
    logic        mw   [2];
    logic [8:0]  ad   [2];
    logic [31:0] wd   [2];
    logic [2:0]  f3   [2];
    logic        st   [2];
    logic        rv   [2];
    logic        er   [2];
    logic [31:0] rdat [2];

    int n_cmp = 0;
    int n_bad = 0;

    dmem_wait_responder #(.WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(reset),
        .MemRead(mr[0]), .MemWrite(mw[0]),
        .addr(ad[0]), .wr_data(wd[0]), .func3(f3[0]),
        .mem_stall(st[0]), .rd_valid(rv[0]),
        .rd_data(rdat[0]), .mem_err(er[0])
    );

    dmem_wait_responder #(.WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset),
        .MemRead(mr[1]), .MemWrite(mw[1]),
        .addr(ad[1]), .wr_data(wd[1]), .func3(f3[1]),
        .mem_stall(st[1]), .rd_valid(rv[1]),
        .rd_data(rdat[1]), .mem_err(er[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request, hold it until completion, check latency and result.
    task automatic access(input int          d,
                          input logic        rd,
                          input logic        wr,
                          input logic [8:0]  a,
                          input logic [31:0] wdv,
                          input logic [2:0]  fv,
                          input logic [31:0] exp_data,
                          input logic        exp_err,
                          input int          exp_lat,
                          input string       tag);
        int lat;
        int stl;
        bit done;
        @(negedge clk);
        mr[d] = rd;
        mw[d] = wr;
        ad[d] = a;
        wd[d] = wdv;
        f3[d] = fv;
        lat  = 0;
        stl  = 0;
        done = 1'b0;
        #1;
        while (!done && lat < 40) begin
            if (rv[d]) begin
                done = 1'b1;
            end else begin
                if (st[d]) stl++;
                @(negedge clk);
                #1;
                lat++;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_stallcyc"}, stl, exp_lat);
        check({tag, "_stall_done"}, {31'd0, st[d]}, 32'd0);
        check({tag, "_err"}, {31'd0, er[d]}, {31'd0, exp_err});
        check({tag, "_data"}, rdat[d], exp_data);
        mr[d] = 1'b0;
        mw[d] = 1'b0;
    endtask

    initial begin
        int pulses;
        int bad_data;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mr[i] = 1'b0;
            mw[i] = 1'b0;
            ad[i] = '0;
            wd[i] = '0;
            f3[i] = '0;
        end
        repeat (3) @(negedge clk);
        mr[0] = 1'b1;
        #1;
        check("rst_stall_req", {31'd0, st[0]}, 32'd0);
        check("rst_valid", {31'd0, rv[0]}, 32'd0);
        check("rst_err", {31'd0, er[0]}, 32'd0);
        check("rst_data", rdat[0], 32'd0);
        @(negedge clk);
        mr[0] = 1'b0;
        reset = 1'b0;
        #1;
        check("post_rst_valid0", {31'd0, rv[0]}, 32'd0);
        check("post_rst_valid1", {31'd0, rv[1]}, 32'd0);

        access(0, 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0, 3, "sw10");
        access(0, 1, 0, 9'h010, 32'h0, 3'b010, 32'hDEADBEEF, 0, 3, "lw10");
        access(0, 0, 1, 9'h011, 32'h000000F0, 3'b000, 32'h0, 0, 3, "sb11");
        access(0, 1, 0, 9'h011, 32'h0, 3'b000, 32'hFFFFFFF0, 0, 3, "lb11");
        access(0, 1, 0, 9'h011, 32'h0, 3'b100, 32'h000000F0, 0, 3, "lbu11");
        access(0, 1, 0, 9'h010, 32'h0, 3'b010, 32'hDEADF0EF, 0, 3, "lw10b");

        access(0, 0, 1, 9'h020, 32'h11223344, 3'b010, 32'h0, 0, 3, "sw20");
        access(0, 0, 1, 9'h022, 32'h00008001, 3'b001, 32'h0, 0, 3, "sh22");
        access(0, 1, 0, 9'h022, 32'h0, 3'b001, 32'hFFFF8001, 0, 3, "lh22");
        access(0, 1, 0, 9'h022, 32'h0, 3'b101, 32'h00008001, 0, 3, "lhu22");
        access(0, 1, 0, 9'h020, 32'h0, 3'b010, 32'h80013344, 0, 3, "lw20");

        access(0, 1, 0, 9'h013, 32'h0, 3'b010, 32'h0, 1, 3, "lw13_mis");
        access(0, 0, 1, 9'h030, 32'hCAFEF00D, 3'b010, 32'h0, 0, 3, "sw30");
        access(0, 0, 1, 9'h031, 32'h0000FFFF, 3'b001, 32'h0, 1, 3, "sh31_mis");
        access(0, 1, 0, 9'h030, 32'h0, 3'b010, 32'hCAFEF00D, 0, 3, "lw30a");
        access(0, 1, 1, 9'h030, 32'h0, 3'b010, 32'h0, 1, 3, "both");
        access(0, 1, 0, 9'h030, 32'h0, 3'b010, 32'hCAFEF00D, 0, 3, "lw30b");
        access(0, 1, 0, 9'h030, 32'h0, 3'b011, 32'h0, 1, 3, "ld_ill");
        access(0, 0, 1, 9'h030, 32'h0, 3'b100, 32'h0, 1, 3, "st_ill");
        access(0, 1, 0, 9'h030, 32'h0, 3'b010, 32'hCAFEF00D, 0, 3, "lw30c");

        access(1, 0, 1, 9'h010, 32'h5A5A5A5A, 3'b010, 32'h0, 0, 1, "w0_sw");
        access(1, 1, 0, 9'h010, 32'h0, 3'b010, 32'h5A5A5A5A, 0, 1, "w0_lw");

        // Held request on the zero-wait instance: one completion every 2 cycles.
        pulses   = 0;
        bad_data = 0;
        @(negedge clk);
        mr[1] = 1'b1;
        ad[1] = 9'h010;
        f3[1] = 3'b010;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (rv[1]) begin
                pulses++;
                if ((i % 2) != 1) bad_data++;
                if (rdat[1] !== 32'h5A5A5A5A) bad_data++;
            end
        end
        @(negedge clk);
        mr[1] = 1'b0;
        check("b2b_pulses", pulses, 8);
        check("b2b_bad", bad_data, 0);

        // Abort a store in its second wait cycle.
        access(0, 0, 1, 9'h040, 32'hAAAA5555, 3'b010, 32'h0, 0, 3, "sw40");
        @(negedge clk);
        mw[0] = 1'b1;
        ad[0] = 9'h040;
        wd[0] = 32'h12345678;
        f3[0] = 3'b010;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        mw[0] = 1'b0;
        #1;
        check("abort_stall_rst", {31'd0, st[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_stall", {31'd0, st[0]}, 32'd0);
        check("abort_valid", {31'd0, rv[0]}, 32'd0);
        check("abort_err", {31'd0, er[0]}, 32'd0);
        check("abort_data", rdat[0], 32'd0);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (rv[0]) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        access(0, 1, 0, 9'h040, 32'h0, 3'b010, 32'hAAAA5555, 0, 3, "lw40");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
